fifo_wr_arb: RTL and testbench

Write-side arbiter and burst sequencer for the 8-bit FIFO write port. Two requesters in the FIFO write clock domain share one FIFO. The block grants the port in fixed-length bursts, round-robin between them, and stalls on `almost_full`, `full` and `wr_rst_busy`. It replaces a single free-running writer and drives `fifo_wr_en`/`fifo_wr_data` directly into the FIFO generator.

---
 rtl/fifo_wr_arb.sv | 148 ++++++++++++++
 tb/tb_fifo_wr_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter: grants the FIFO write port to one of two requesters in fixed-length bursts.
// Optional completed-burst counters are built when FIFO_WR_ARB_STAT_EN is defined.
//
// state | meaning
// IDLE  | no grant; waiting for a request while the FIFO is writable
// BURST | one requester owns the port; beats counted until BURST_LEN or abort
module fifo_wr_arb #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  input  logic              full,
  input  logic              almost_full,
  input  logic              wr_rst_busy,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              busy,
  output logic [15:0]       stat_bursts0,
  output logic [15:0]       stat_bursts1
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t              state_q, state_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic                last_q, last_d;
  logic                stall;

  // almost_full counts as a stall because one registered write is always in flight
  assign stall = full | almost_full | wr_rst_busy;
  assign busy  = (state_q == BURST);
  assign ack0  = gnt0_q & busy & ~stall & req0;
  assign ack1  = gnt1_q & busy & ~stall & req1;

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;

  always_comb begin
    state_d   = state_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    beat_d    = beat_q;
    last_d    = last_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (!stall && (req0 || req1)) begin
          state_d = BURST;
          beat_d  = '0;
          // last_q=1 means requester 1 owned the previous burst, so 0 wins a tie
          if (req0 && (!req1 || last_q)) gnt0_d = 1'b1;
          else                           gnt1_d = 1'b1;
        end
      end
      BURST: begin
        if ((gnt0_q && !req0) || (gnt1_q && !req1)) begin
          state_d = IDLE;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          last_d  = gnt1_q;
        end else if (ack0 || ack1) begin
          wr_en_d   = 1'b1;
          wr_data_d = ack1 ? din1 : din0;
          beat_d    = beat_q + CNT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            done0_d = gnt0_q;
            done1_d = gnt1_q;
            last_d  = gnt1_q;
            beat_d  = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      beat_q    <= '0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
    end
  end

`ifdef FIFO_WR_ARB_STAT_EN
  logic [15:0] stat0_q, stat1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      if (done0_d) stat0_q <= stat0_q + 16'd1;
      if (done1_d) stat1_q <= stat1_q + 16'd1;
    end
  end

  assign stat_bursts0 = stat0_q;
  assign stat_bursts1 = stat1_q;
`else
  assign stat_bursts0 = 16'h0000;
  assign stat_bursts1 = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb with BURST_LEN=4: directed scenarios plus a randomized run against a
// transaction-level model (owner / bytes sent / last owner).
module tb_fifo_wr_arb;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  din0 = 8'h00, din1 = 8'h00;
  logic        full = 1'b0, almost_full = 1'b0, wr_rst_busy = 1'b0;
  logic        gnt0, gnt1, ack0, ack1, done0, done1, fifo_wr_en, busy;
  logic [7:0]  fifo_wr_data;
  logic [15:0] stat_bursts0, stat_bursts1;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_arb #(.DATA_W(8), .BURST_LEN(BL), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .full(full), .almost_full(almost_full), .wr_rst_busy(wr_rst_busy),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .busy(busy),
    .stat_bursts0(stat_bursts0), .stat_bursts1(stat_bursts1)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    @(negedge clk);
    req0 = 0; req1 = 0; full = 0; almost_full = 0; wr_rst_busy = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset;
    #2 rst_n = 0;
    #1;
    n_tests++;
    if ({gnt0, gnt1, done0, done1, fifo_wr_en, busy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, done0, done1, fifo_wr_en, busy});
    end
    n_tests++;
    if (fifo_wr_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h want 00", fifo_wr_data);
    end
    n_tests++;
    if (stat_bursts0 !== 16'h0 || stat_bursts1 !== 16'h0) begin
      n_fail++; $display("FAIL reset_stat: got %h/%h want 0000/0000", stat_bursts0, stat_bursts1);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single_burst;
    int acks = 0, first_gnt = -1, n_wr = 0, n_done = 0, bad = 0, done_bad = 0, first_wr = -1, last_wr = -1, gnt_cyc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req0 = (acks < BL);
      din0 = 8'h10 + 8'(acks);
      #1;
      if (gnt0) begin gnt_cyc++; if (first_gnt < 0) first_gnt = c; end
      if (ack0) acks++;
      if (fifo_wr_en) begin
        if (fifo_wr_data !== 8'h10 + 8'(n_wr)) bad++;
        n_wr++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end
      if (done0) begin
        n_done++;
        if (!(fifo_wr_en && fifo_wr_data === 8'h13)) done_bad++;
      end
    end
    n_tests++;
    if (first_gnt !== 1) begin n_fail++; $display("FAIL single_gnt_latency: got %0d want 1", first_gnt); end
    n_tests++;
    if (gnt_cyc !== BL) begin n_fail++; $display("FAIL single_gnt_len: got %0d want %0d", gnt_cyc, BL); end
    n_tests++;
    if (n_wr !== BL || bad !== 0) begin n_fail++; $display("FAIL single_writes: got %0d writes %0d bad want 4 writes 0 bad", n_wr, bad); end
    n_tests++;
    if (last_wr - first_wr !== BL - 1) begin n_fail++; $display("FAIL single_consecutive: got span %0d want 3", last_wr - first_wr); end
    n_tests++;
    if (n_done !== 1 || done_bad !== 0) begin n_fail++; $display("FAIL single_done: got %0d done %0d misaligned want 1 done 0 misaligned", n_done, done_bad); end
  endtask

  task automatic test_round_robin;
    int dones = 0, nr = 0, n_wr = 0;
    int owner_seq[4];
    int rise_c[4];
    logic prev = 1'b0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done0 | done1) dones++;
      if (fifo_wr_en) n_wr++;
      if ((gnt0 | gnt1) && !prev) begin
        if (nr < 4) begin owner_seq[nr] = gnt1 ? 1 : 0; rise_c[nr] = c; end
        nr++;
      end
      prev = gnt0 | gnt1;
      req0 = (dones < 4);
      req1 = (dones < 4);
      din0 = 8'($urandom);
      din1 = 8'($urandom);
    end
    req0 = 0; req1 = 0;
    n_tests++;
    if (nr !== 4) begin n_fail++; $display("FAIL rr_grants: got %0d grants want 4", nr); end
    for (int i = 0; i < 4 && i < nr; i++) begin
      n_tests++;
      if (owner_seq[i] !== (i % 2)) begin n_fail++; $display("FAIL rr_owner[%0d]: got %0d want %0d", i, owner_seq[i], i % 2); end
      if (i > 0) begin
        n_tests++;
        if (rise_c[i] - rise_c[i-1] !== BL + 1) begin
          n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", i, rise_c[i] - rise_c[i-1], BL + 1);
        end
      end
    end
    n_tests++;
    if (n_wr !== 4 * BL) begin n_fail++; $display("FAIL rr_writes: got %0d want %0d", n_wr, 4 * BL); end
`ifdef FIFO_WR_ARB_STAT_EN
    n_tests++;
    if (stat_bursts0 !== 16'd2 || stat_bursts1 !== 16'd2) begin
      n_fail++; $display("FAIL rr_stat: got %0d/%0d want 2/2", stat_bursts0, stat_bursts1);
    end
`else
    n_tests++;
    if (stat_bursts0 !== 16'd0 || stat_bursts1 !== 16'd0) begin
      n_fail++; $display("FAIL rr_stat_off: got %0d/%0d want 0/0", stat_bursts0, stat_bursts1);
    end
`endif
  endtask

  task automatic test_stall;
    int acks = 0, af_n = 0, n_wr = 0, n_done = 0, ack_in_af = 0, wr_after_af = 0, bad = 0, gnt_drop = 0;
    logic af_prev;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      af_prev = almost_full;
      if (fifo_wr_en) begin
        if (fifo_wr_data !== 8'h20 + 8'(n_wr)) bad++;
        n_wr++;
        if (af_prev) wr_after_af++;
      end
      if (done0) n_done++;
      if (acks >= 2 && af_n < 3) begin almost_full = 1; af_n++; end
      else almost_full = 0;
      req0 = (acks < BL);
      din0 = 8'h20 + 8'(acks);
      #1;
      if (ack0) begin acks++; if (almost_full) ack_in_af++; end
      if (almost_full && !gnt0) gnt_drop++;
    end
    almost_full = 0;
    n_tests++;
    if (ack_in_af !== 0 || af_n !== 3) begin n_fail++; $display("FAIL stall_ack: got %0d acks in %0d stall cycles want 0 in 3", ack_in_af, af_n); end
    n_tests++;
    if (wr_after_af !== 0) begin n_fail++; $display("FAIL stall_wr: got %0d writes during stall want 0", wr_after_af); end
    n_tests++;
    if (n_wr !== BL || bad !== 0 || n_done !== 1) begin
      n_fail++; $display("FAIL stall_total: got %0d writes %0d bad %0d done want 4/0/1", n_wr, bad, n_done);
    end
    n_tests++;
    if (gnt_drop !== 0) begin n_fail++; $display("FAIL stall_gnt_held: got %0d drops want 0", gnt_drop); end
  endtask

  task automatic test_wr_rst_busy;
    int early = 0, acks = 0, n_wr = 0, n_done = 0, bad = 0, wb_n = 0;
    logic gnt_after;
    @(negedge clk);
    wr_rst_busy = 1; req1 = 1; din1 = 8'h30;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (gnt1) early++;
    end
    @(negedge clk);
    wr_rst_busy = 0;
    #1;
    if (gnt1) early++;
    @(negedge clk);
    #1;
    gnt_after = gnt1;
    if (ack1) acks++;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (fifo_wr_en) begin if (fifo_wr_data !== 8'h30 + 8'(n_wr)) bad++; n_wr++; end
      if (done1) n_done++;
      wr_rst_busy = (acks == 2 && wb_n < 2);
      if (wr_rst_busy) wb_n++;
      req1 = (acks < BL);
      din1 = 8'h30 + 8'(acks);
      #1;
      if (ack1) begin acks++; if (wr_rst_busy) bad++; end
      if (wr_rst_busy && !gnt1) bad++;
    end
    wr_rst_busy = 0; req1 = 0;
    n_tests++;
    if (early !== 0) begin n_fail++; $display("FAIL wrb_block: got %0d grant cycles while busy want 0", early); end
    n_tests++;
    if (gnt_after !== 1'b1) begin n_fail++; $display("FAIL wrb_release: got gnt1=%b want 1", gnt_after); end
    n_tests++;
    if (n_wr !== BL || n_done !== 1 || bad !== 0 || wb_n !== 2) begin
      n_fail++; $display("FAIL wrb_burst: got %0d writes %0d done %0d bad want 4/1/0", n_wr, n_done, bad);
    end
  endtask

  task automatic test_abort;
    int acks = 0, n_wr = 0, n_done = 0, c_drop = -1;
    logic gnt_after = 1'b1;
    logic [1:0] tie;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_wr_en) n_wr++;
      if (done0) n_done++;
      req0 = (acks < 2);
      din0 = 8'h60 + 8'(acks);
      if (!req0 && c_drop < 0) c_drop = c;
      #1;
      if (ack0) acks++;
      if (c_drop >= 0 && c == c_drop + 1) gnt_after = gnt0;
    end
    @(negedge clk);
    req0 = 1; req1 = 1;
    @(negedge clk);
    #1;
    tie = {gnt1, gnt0};
    @(negedge clk);
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (acks !== 2 || n_wr !== 2) begin n_fail++; $display("FAIL abort_writes: got %0d acks %0d writes want 2/2", acks, n_wr); end
    n_tests++;
    if (gnt_after !== 1'b0) begin n_fail++; $display("FAIL abort_gnt: got gnt0=%b want 0", gnt_after); end
    n_tests++;
    if (n_done !== 0 || stat_bursts0 !== 16'd0) begin n_fail++; $display("FAIL abort_done: got %0d done stat %0d want 0/0", n_done, stat_bursts0); end
    n_tests++;
    if (tie !== 2'b10) begin n_fail++; $display("FAIL abort_pointer: got {gnt1,gnt0}=%b want 10", tie); end
  endtask

  task automatic test_reset_mid_burst;
    int acks = 0, n_wr = 0, n_done = 0, bad = 0;
    logic wr_before;
    do_reset();
    for (int c = 0; c < 10 && acks < 2; c++) begin
      @(negedge clk);
      req0 = 1; din0 = 8'h40 + 8'(acks);
      #1;
      if (ack0) acks++;
    end
    @(negedge clk);
    #2;
    wr_before = fifo_wr_en;
    rst_n = 0;
    #1;
    n_tests++;
    if (wr_before !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got fifo_wr_en=%b want 1", wr_before); end
    n_tests++;
    if ({gnt0, fifo_wr_en, busy} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_clear: got gnt0/wr_en/busy=%b want 000", {gnt0, fifo_wr_en, busy});
    end
    @(negedge clk);
    rst_n = 1;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_wr_en) begin if (fifo_wr_data !== 8'h50 + 8'(n_wr)) bad++; n_wr++; end
      if (done0) n_done++;
      req0 = (acks < BL);
      din0 = 8'h50 + 8'(acks);
      #1;
      if (ack0) acks++;
    end
    req0 = 0;
    n_tests++;
    if (n_wr !== BL || bad !== 0 || n_done !== 1) begin
      n_fail++; $display("FAIL rstmid_restart: got %0d writes %0d bad %0d done want 4/0/1", n_wr, bad, n_done);
    end
  endtask

  task automatic test_random;
    int m_owner = -1, m_last = 1, m_sent = 0, errs = 0;
    int m_stat[2];
    int racks[2];
    logic rq[2];
    logic m_wr = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [1:0] m_done = 2'b00;
    logic stall, e_ack0, e_ack1;
    logic [15:0] e_s0, e_s1;
    m_stat[0] = 0; m_stat[1] = 0; racks[0] = 0; racks[1] = 0; rq[0] = 0; rq[1] = 0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (rq[n]) begin
          if (racks[n] >= BL || (m_owner == n && $urandom_range(0, 39) == 0)) begin
            rq[n] = 0; racks[n] = 0;
          end
        end else if ($urandom_range(0, 2) == 0) rq[n] = 1;
      end
      req0 = rq[0]; req1 = rq[1];
      din0 = 8'($urandom); din1 = 8'($urandom);
      full        = ($urandom_range(0, 9) == 0);
      almost_full = ($urandom_range(0, 5) == 0);
      wr_rst_busy = ($urandom_range(0, 14) == 0);
      #1;
      stall  = full | almost_full | wr_rst_busy;
      e_ack0 = (m_owner == 0) && req0 && !stall;
      e_ack1 = (m_owner == 1) && req1 && !stall;
`ifdef FIFO_WR_ARB_STAT_EN
      e_s0 = 16'(m_stat[0]); e_s1 = 16'(m_stat[1]);
`else
      e_s0 = 16'h0; e_s1 = 16'h0;
`endif
      n_tests++;
      if (gnt0 !== (m_owner == 0) || gnt1 !== (m_owner == 1) || busy !== (m_owner >= 0) ||
          ack0 !== e_ack0 || ack1 !== e_ack1 || fifo_wr_en !== m_wr || (m_wr && fifo_wr_data !== m_data) ||
          done0 !== m_done[0] || done1 !== m_done[1] || stat_bursts0 !== e_s0 || stat_bursts1 !== e_s1) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cyc %0d: got gnt=%b%b ack=%b%b wr=%b/%h done=%b%b stat=%0d/%0d, want owner=%0d ack=%b%b wr=%b/%h done=%b stat=%0d/%0d",
                   cyc, gnt1, gnt0, ack1, ack0, fifo_wr_en, fifo_wr_data, done1, done0, stat_bursts0, stat_bursts1,
                   m_owner, e_ack1, e_ack0, m_wr, m_data, m_done, e_s0, e_s1);
      end
      m_wr = 0;
      m_done = 2'b00;
      if (m_owner < 0) begin
        if (!stall && (req0 || req1)) begin
          m_owner = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
          m_sent = 0;
        end
      end else if (!(m_owner == 0 ? req0 : req1)) begin
        m_last = m_owner;
        m_owner = -1;
      end else if (!stall) begin
        m_wr = 1;
        m_data = (m_owner == 0) ? din0 : din1;
        m_sent++;
        racks[m_owner]++;
        if (m_sent == BL) begin
          m_done[m_owner] = 1'b1;
          m_stat[m_owner] = (m_stat[m_owner] + 1) % 65536;
          m_last = m_owner;
          m_owner = -1;
        end
      end
    end
    @(negedge clk);
    req0 = 0; req1 = 0; full = 0; almost_full = 0; wr_rst_busy = 0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_stall();
    test_wr_rst_busy();
    test_abort();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
